// File: rtl/aud_pkg.sv
// Shared audio-path definitions: sample/address widths, last SRAM address
// and the recorder state encoding. The playback DSP uses the same ADDR_MAX.
package aud_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 20;

  // Last usable SRAM word address (2^ADDR_W - 1).
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE,
    WAIT_L,
    SHIFT,
    STORE,
    PAUSED
  } state_e;

endpackage

// File: rtl/aud_i2s_deser.sv
// I2S left-channel deserializer: LRC falling-edge detect, bit counter and
// MSB-first shift register. The recorder FSM decides when counting starts
// (i_clr at the left-channel start) and when bits are taken (i_shift_en).
//   i_clk, i_daclrck    : bit clock, async active-high reset
//   i_lrc, i_data       : ADC LR clock and serial data
//   i_clr               : clear bit counter (edge 0 accepted by the FSM)
//   i_shift_en          : sample i_data into the shift register this edge
//   o_left_start_c      : combinational, lrc_d=1 and i_lrc=0 (edge 0)
//   o_last_bit_c        : combinational, this edge shifts the final bit
//   o_sample_valid      : one cycle after the final bit was shifted
//   o_sample            : assembled sample word
module aud_i2s_deser
  import aud_pkg::*;
#(
  parameter int unsigned SMP_W = DATA_W
) (
  input  logic             i_clk,
  input  logic             i_daclrck,
  input  logic             i_lrc,
  input  logic             i_data,
  input  logic             i_clr,
  input  logic             i_shift_en,
  output logic             o_left_start_c,
  output logic             o_last_bit_c,
  output logic             o_sample_valid,
  output logic [SMP_W-1:0] o_sample
);

  localparam int unsigned CNT_W = $clog2(SMP_W + 1);

  logic             lrc_d;
  logic [CNT_W-1:0] cnt_q;
  logic [SMP_W-1:0] shreg_q;
  logic             valid_q;

  assign o_left_start_c = lrc_d & ~i_lrc;
  assign o_last_bit_c   = i_shift_en && (cnt_q == CNT_W'(SMP_W - 1));
  assign o_sample_valid = valid_q;
  assign o_sample       = shreg_q;

  // LRC history for edge detection
  always_ff @(posedge i_clk or posedge i_daclrck) begin
    if (i_daclrck) lrc_d <= 1'b0;
    else           lrc_d <= i_lrc;
  end

  // Bit counter and shift register; a partial word is simply overwritten
  // by the next capture since the counter restarts on i_clr.
  always_ff @(posedge i_clk or posedge i_daclrck) begin
    if (i_daclrck) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= o_last_bit_c;
      if (i_clr) begin
        cnt_q <= '0;
      end else if (i_shift_en) begin
        cnt_q   <= cnt_q + CNT_W'(1);
        shreg_q <= {shreg_q[SMP_W-2:0], i_data};
      end
    end
  end

endmodule

// File: rtl/aud_recorder.sv
// Record path: captures left-channel I2S samples and writes them to SRAM
// at sequential addresses starting from 0, under start/pause/stop control.
//   i_clk, i_daclrck        : bit clock, async active-high reset
//   i_lrc, i_data           : ADC LR clock (low = left) and serial data
//   i_start/i_pause/i_stop  : one-cycle control pulses (stop > pause > start)
//   o_address, o_data, o_wr : SRAM write port, one-cycle strobe per sample
//   o_len                   : samples written in current/last recording
//   o_done                  : one-cycle pulse when a recording ends
module aud_recorder
  import aud_pkg::*;
#(
  parameter int unsigned SMP_W = DATA_W,
  parameter int unsigned ADR_W = ADDR_W
) (
  input  logic             i_clk,
  input  logic             i_daclrck,
  input  logic             i_lrc,
  input  logic             i_data,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_stop,
  output logic [ADR_W-1:0] o_address,
  output logic [SMP_W-1:0] o_data,
  output logic             o_wr,
  output logic [ADR_W:0]   o_len,
  output logic             o_done
);

  localparam logic [ADR_W-1:0] ADR_LAST = {ADR_W{1'b1}};

  state_e           state_q, state_d;
  logic [ADR_W-1:0] addr_q, addr_d;
  logic [SMP_W-1:0] data_q, data_d;
  logic             wr_q, wr_d;
  logic [ADR_W:0]   len_q, len_d;
  logic             done_q, done_d;

  logic             left_start_c;
  logic             last_bit_c;
  logic             sample_valid;
  logic [SMP_W-1:0] sample;
  logic             capture_start_c;
  logic             shift_en_c;

  // A control pulse on the same edge overrides capture activity.
  assign capture_start_c = (state_q == WAIT_L) && left_start_c && !i_stop && !i_pause;
  assign shift_en_c      = (state_q == SHIFT) && !i_stop && !i_pause;

  aud_i2s_deser #(
    .SMP_W(SMP_W)
  ) u_deser (
    .i_clk          (i_clk),
    .i_daclrck      (i_daclrck),
    .i_lrc          (i_lrc),
    .i_data         (i_data),
    .i_clr          (capture_start_c),
    .i_shift_en     (shift_en_c),
    .o_left_start_c (left_start_c),
    .o_last_bit_c   (last_bit_c),
    .o_sample_valid (sample_valid),
    .o_sample       (sample)
  );

  assign o_address = addr_q;
  assign o_data    = data_q;
  assign o_wr      = wr_q;
  assign o_len     = len_q;
  assign o_done    = done_q;

  // State register
  always_ff @(posedge i_clk or posedge i_daclrck) begin
    if (i_daclrck) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Output and counter registers
  always_ff @(posedge i_clk or posedge i_daclrck) begin
    if (i_daclrck) begin
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      len_q  <= '0;
      done_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q   <= wr_d;
      len_q  <= len_d;
      done_q <= done_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    len_d   = len_q;
    done_d  = 1'b0;

    // Counters advance on the edge that ends the write strobe; the last
    // address does not wrap and instead completes the recording.
    if (wr_q) begin
      len_d = len_q + (ADR_W + 1)'(1);
      if (addr_q != ADR_LAST) addr_d = addr_q + ADR_W'(1);
      else                    done_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = WAIT_L;
          addr_d  = '0;
          len_d   = '0;
        end
      end
      WAIT_L: begin
        if (i_stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (i_pause) begin
          state_d = PAUSED;
        end else if (left_start_c) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (i_stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (i_pause) begin
          state_d = PAUSED;
        end else if (last_bit_c) begin
          state_d = STORE;
        end
      end
      STORE: begin
        // Stop aborts the pending write; pause lets it complete.
        if (i_stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          wr_d   = sample_valid;
          data_d = sample;
          if (addr_q == ADR_LAST) state_d = IDLE;
          else if (i_pause)       state_d = PAUSED;
          else                    state_d = WAIT_L;
        end
      end
      PAUSED: begin
        if (i_stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (i_pause) begin
          state_d = WAIT_L;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aud_recorder.sv
module tb_aud_recorder;

  localparam int unsigned DW   = 16;
  localparam int unsigned AW   = 4;
  localparam int          HALF = 20;

  logic          i_clk = 1'b0;
  logic          i_daclrck;
  logic          i_lrc;
  logic          i_data;
  logic          i_start;
  logic          i_pause;
  logic          i_stop;
  logic [AW-1:0] o_address;
  logic [DW-1:0] o_data;
  logic          o_wr;
  logic [AW:0]   o_len;
  logic          o_done;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cyc = 0;
  int   exp_done = 0;

  aud_recorder #(
    .SMP_W(DW),
    .ADR_W(AW)
  ) dut (
    .i_clk     (i_clk),
    .i_daclrck (i_daclrck),
    .i_lrc     (i_lrc),
    .i_data    (i_data),
    .i_start   (i_start),
    .i_pause   (i_pause),
    .i_stop    (i_stop),
    .o_address (o_address),
    .o_data    (o_data),
    .o_wr      (o_wr),
    .o_len     (o_len),
    .o_done    (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Write scoreboard and done-pulse counter, sampled on the falling edge
  always @(negedge i_clk) begin
    if (o_done) done_cyc++;
    if (o_wr) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_wr got addr=%0h data=%0h exp no write", o_address, o_data);
      end
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        assert ({o_address, o_data} === {e.addr, e.data}) else begin
          errors++;
          $error("FAIL write got addr=%0h data=%0h exp addr=%0h data=%0h",
                 o_address, o_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // One LRC period: left half first; ctrl = {start,pause,stop} at cycle ctrl_c
  task automatic send_frame(input logic [DW-1:0] left, input logic [DW-1:0] right,
                            input int ctrl_c, input logic [2:0] ctrl, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge i_clk);
      i_lrc = (c >= HALF);
      if (c >= 1 && c <= DW)                    i_data = left[DW-c];
      else if (c >= HALF + 1 && c <= HALF + DW) i_data = right[HALF+DW-c];
      else                                      i_data = 1'b1;
      {i_start, i_pause, i_stop} = (c == ctrl_c) ? ctrl : 3'b000;
    end
  endtask

  task automatic frame(input logic [DW-1:0] left);
    send_frame(left, 16'hFFFF, -1, 3'b000, 2 * HALF);
  endtask

  task automatic pulse(input logic [2:0] ctrl);
    @(negedge i_clk);
    i_lrc = 1'b1;
    i_data = 1'b1;
    {i_start, i_pause, i_stop} = ctrl;
    @(negedge i_clk);
    {i_start, i_pause, i_stop} = 3'b000;
  endtask

  initial begin
    i_daclrck = 1'b1;
    i_lrc     = 1'b1;
    i_data    = 1'b0;
    {i_start, i_pause, i_stop} = 3'b000;
    repeat (3) @(negedge i_clk);
    chk("rst_addr", 32'(o_address), 32'h0);
    chk("rst_data", 32'(o_data), 32'h0);
    chk("rst_wr", 32'(o_wr), 32'h0);
    chk("rst_len", 32'(o_len), 32'h0);
    chk("rst_done", 32'(o_done), 32'h0);
    i_daclrck = 1'b0;

    // Three left samples, right channel ignored
    pulse(3'b100);
    push(4'd0, 16'h8001); frame(16'h8001);
    push(4'd1, 16'h7FFE); frame(16'h7FFE);
    push(4'd2, 16'h1234); frame(16'h1234);
    chk("len3", 32'(o_len), 32'd3);
    chk("no_done_1", 32'(done_cyc), 32'(exp_done));

    // Stop during SHIFT: no write, one done pulse, length held
    send_frame(16'hDEAD, 16'hFFFF, 8, 3'b001, 2 * HALF);
    exp_done++;
    chk("stop_done", 32'(done_cyc), 32'(exp_done));
    chk("stop_len", 32'(o_len), 32'd3);
    chk("stop_addr", 32'(o_address), 32'd3);
    frame(16'h4444);

    // New recording restarts at 0; pause mid-sample discards it
    pulse(3'b100);
    chk("restart_len", 32'(o_len), 32'd0);
    chk("restart_addr", 32'(o_address), 32'd0);
    push(4'd0, 16'h0F0F); frame(16'h0F0F);
    chk("len1", 32'(o_len), 32'd1);
    push(4'd1, 16'hF0F0); frame(16'hF0F0);
    send_frame(16'h9999, 16'hFFFF, 8, 3'b010, 2 * HALF);
    chk("pause_len", 32'(o_len), 32'd2);
    send_frame(16'h5555, 16'hFFFF, 30, 3'b010, 2 * HALF);
    push(4'd2, 16'hA5C3); frame(16'hA5C3);
    chk("resume_len", 32'(o_len), 32'd3);

    // Stop and pause together in WAIT_L: stop wins
    push(4'd3, 16'h6666);
    send_frame(16'h6666, 16'hFFFF, 25, 3'b011, 2 * HALF);
    exp_done++;
    chk("stoppause_done", 32'(done_cyc), 32'(exp_done));
    chk("stoppause_len", 32'(o_len), 32'd4);
    pulse(3'b010);
    pulse(3'b001);
    frame(16'h7777);
    chk("idle_ignore_done", 32'(done_cyc), 32'(exp_done));
    chk("idle_ignore_len", 32'(o_len), 32'd4);

    // Fill memory: last address ends the recording, no wrap
    pulse(3'b100);
    for (int k = 0; k < 16; k++) begin
      logic [DW-1:0] d;
      d = 16'(16'hC000 + k * 16'h0103);
      push(AW'(k), d);
      frame(d);
    end
    exp_done++;
    chk("full_len", 32'(o_len), 32'd16);
    chk("full_done", 32'(done_cyc), 32'(exp_done));
    chk("full_addr", 32'(o_address), 32'd15);
    frame(16'h1111);
    chk("full_idle_len", 32'(o_len), 32'd16);

    // Reset mid-SHIFT aborts at once
    pulse(3'b100);
    push(4'd0, 16'h2468); frame(16'h2468);
    send_frame(16'h3C3C, 16'hFFFF, -1, 3'b000, 9);
    i_daclrck = 1'b1;
    #1;
    chk("arst_addr", 32'(o_address), 32'h0);
    chk("arst_data", 32'(o_data), 32'h0);
    chk("arst_wr", 32'(o_wr), 32'h0);
    chk("arst_len", 32'(o_len), 32'h0);
    chk("arst_done", 32'(o_done), 32'h0);
    repeat (2) @(negedge i_clk);
    i_lrc = 1'b1;
    i_daclrck = 1'b0;
    pulse(3'b010);
    pulse(3'b001);
    frame(16'h5A5A);
    chk("post_rst_done", 32'(done_cyc), 32'(exp_done));
    chk("post_rst_len", 32'(o_len), 32'd0);
    pulse(3'b100);
    push(4'd0, 16'hBEEF); frame(16'hBEEF);
    chk("post_rst_len1", 32'(o_len), 32'd1);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
